// File: rtl/conv_stream_112_49.sv
// Streaming valid-region 1-D convolution: load N x and M f, then emit N-M+1 sums, one every M+1 cycles minimum.
// y held under backpressure (all state frozen); optional ReLU on the output register via CONV_RELU_EN.
module conv_stream_112_49 #(
  parameter int N  = 112,
  parameter int M  = 49,
  parameter int XW = 10,
  parameter int YW = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [XW-1:0] x_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic signed [XW-1:0] f_data,
  input  logic                 f_valid,
  output logic                 f_ready,
  output logic signed [YW-1:0] y_data,
  output logic                 y_valid,
  input  logic                 y_ready
);
  localparam int XCW = $clog2(N + 1);
  localparam int FCW = $clog2(M + 1);
  localparam int XAW = $clog2(N);
  localparam int FAW = $clog2(M);
  localparam logic [XCW-1:0] N_C    = XCW'(N);
  localparam logic [XCW-1:0] M_LAST = XCW'(N - M);
  localparam logic [FCW-1:0] M_C    = FCW'(M);
  localparam logic [FCW-1:0] J_LAST = FCW'(M - 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;
  state_t state, state_nxt;

  logic signed [XW-1:0] x_mem [N];
  logic signed [XW-1:0] f_mem [M];

  logic [XCW-1:0] xc, m, xc_inc, x_idx;
  logic [FCW-1:0] fc, j, fc_inc;
  logic signed [YW-1:0]   acc, sum, y_nxt;
  logic signed [2*XW-1:0] xs, fs, prod;
  logic x_acc, f_acc, y_acc, last_j, last_m;
  logic x_ready_d, f_ready_d;

  assign x_acc  = x_valid && x_ready;
  assign f_acc  = f_valid && f_ready;
  assign y_acc  = y_valid && y_ready;
  assign xc_inc = xc + XCW'(x_acc);
  assign fc_inc = fc + FCW'(f_acc);
  assign last_j = (j == J_LAST);
  assign last_m = (m == M_LAST);

  // Operands widened first so the product is the exact 2*XW-bit value.
  assign x_idx = m + XCW'(j);
  assign xs    = {{XW{x_mem[x_idx[XAW-1:0]][XW-1]}}, x_mem[x_idx[XAW-1:0]]};
  assign fs    = {{XW{f_mem[j[FAW-1:0]][XW-1]}}, f_mem[j[FAW-1:0]]};
  assign prod  = xs * fs;
  assign sum   = acc + {{(YW-2*XW){prod[2*XW-1]}}, prod};

`ifdef CONV_RELU_EN
  assign y_nxt = sum[YW-1] ? '0 : sum;
`else
  assign y_nxt = sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (xc_inc == N_C && fc_inc == M_C) state_nxt = COMPUTE;
      COMPUTE: if (last_j) state_nxt = OUTPUT;
      OUTPUT:  if (y_acc) state_nxt = last_m ? LOAD : COMPUTE;
      default: state_nxt = LOAD;
    endcase
  end

  // Ready is registered off the post-edge counters, so it drops on the edge taking the last word.
  always_comb begin
    x_ready_d = (state == LOAD) && (xc_inc < N_C);
    f_ready_d = (state == LOAD) && (fc_inc < M_C);
  end

  always_ff @(posedge clk) begin
    if (x_acc) x_mem[xc[XAW-1:0]] <= x_data;
    if (f_acc) f_mem[fc[FAW-1:0]] <= f_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xc      <= '0;
      fc      <= '0;
      m       <= '0;
      j       <= '0;
      acc     <= '0;
      y_data  <= '0;
      y_valid <= 1'b0;
      x_ready <= 1'b0;
      f_ready <= 1'b0;
    end else begin
      x_ready <= x_ready_d;
      f_ready <= f_ready_d;
      case (state)
        LOAD: begin
          xc  <= xc_inc;
          fc  <= fc_inc;
          m   <= '0;
          j   <= '0;
          acc <= '0;
        end
        COMPUTE: begin
          if (last_j) begin
            y_data  <= y_nxt;
            y_valid <= 1'b1;
          end else begin
            acc <= sum;
            j   <= j + 1'b1;
          end
        end
        OUTPUT: begin
          if (y_acc) begin
            y_valid <= 1'b0;
            j       <= '0;
            acc     <= '0;
            if (last_m) begin
              xc <= '0;
              fc <= '0;
              m  <= '0;
            end else begin
              m <= m + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
